// File: rtl/reu_dma_seq.sv
// reu_dma_seq -- REU DMA sequencer.
// Takes a start request and transfer type from the REU register block.
// Sequences C64 bus cycles and SDRAM request/acknowledge handshakes one byte
// at a time, and returns per-byte advance strobes and end/status pulses.
// The byte data itself moves through an external datapath; this block only
// drives the control strobes for it.
// All state changes on the falling edge of PHI2.
//
// Ports:
//   i_PHI2          C64 PHI2 clock (falling edge active)
//   i_Reset         synchronous active-high reset
//   i_Execute       start request
//   i_XferType      00 stash, 01 fetch, 10 swap, 11 verify
//   i_Length1       remaining length == 1
//   i_BA            C64 bus available (0 = VIC owns the bus)
//   i_RAMAck        one-cycle SDRAM completion pulse
//   i_DataEqual     C64Data == RAMData
//   o_DMA           request C64 bus
//   o_C64Rd/o_C64Wr C64 read / write strobes
//   o_RAMReq/o_RAMWr SDRAM request and direction
//   o_IncCA/o_IncREUA/o_DecLen  per-byte advance strobes
//   o_XferEnd, o_SetEndOfBlock, o_SetVerifyErr  one-cycle pulses
//   o_Busy          sequencer not idle
module reu_dma_seq #(
  parameter int ARM_CYCLES = 1
) (
  input  logic       i_PHI2,
  input  logic       i_Reset,
  input  logic       i_Execute,
  input  logic [1:0] i_XferType,
  input  logic       i_Length1,
  input  logic       i_BA,
  input  logic       i_RAMAck,
  input  logic       i_DataEqual,
  output logic       o_DMA,
  output logic       o_C64Rd,
  output logic       o_C64Wr,
  output logic       o_RAMReq,
  output logic       o_RAMWr,
  output logic       o_IncCA,
  output logic       o_IncREUA,
  output logic       o_DecLen,
  output logic       o_XferEnd,
  output logic       o_SetEndOfBlock,
  output logic       o_SetVerifyErr,
  output logic       o_Busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_C64RD = 3'd2;
  localparam logic [2:0] S_C64WR = 3'd3;
  localparam logic [2:0] S_RAMRD = 3'd4;
  localparam logic [2:0] S_RAMWR = 3'd5;
  localparam logic [2:0] S_ADV   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] T_STASH  = 2'b00;
  localparam logic [1:0] T_FETCH  = 2'b01;
  localparam logic [1:0] T_SWAP   = 2'b10;
  localparam logic [1:0] T_VERIFY = 2'b11;

  localparam logic [1:0] ARM_LOAD = 2'(ARM_CYCLES);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_type;
  logic [1:0] r_arm;
  logic [2:0] w_first;
  logic       w_mismatch;

  // Stash starts by reading the C64; every other type reads SDRAM first.
  assign w_first    = (r_type == T_STASH) ? S_C64RD : S_RAMRD;
  assign w_mismatch = (r_type == T_VERIFY) && !i_DataEqual;

  // The step after a bus cycle depends only on the current state and the
  // latched type, so no separate step counter is needed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_Execute) w_next = S_ARM;
      S_ARM:   if (r_arm <= 2'd1) w_next = w_first;
      S_C64RD: if (i_BA) w_next = (r_type == T_VERIFY) ? S_ADV : S_RAMWR;
      S_C64WR: if (i_BA) w_next = S_ADV;
      S_RAMRD: if (i_RAMAck) w_next = (r_type == T_FETCH) ? S_C64WR : S_C64RD;
      S_RAMWR: if (i_RAMAck) w_next = (r_type == T_SWAP) ? S_C64WR : S_ADV;
      S_ADV:   w_next = (w_mismatch || i_Length1) ? S_DONE : w_first;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge i_PHI2) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_type  <= T_STASH;
      r_arm   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_Execute) begin
        r_type <= i_XferType;
        r_arm  <= ARM_LOAD;
      end else if (r_state == S_ARM && r_arm != 2'd0) begin
        r_arm <= r_arm - 2'd1;
      end
    end
  end

  // C64 strobes are qualified by BA so nothing hits the bus while VIC owns it.
  assign o_DMA           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_C64Rd         = (r_state == S_C64RD) && i_BA;
  assign o_C64Wr         = (r_state == S_C64WR) && i_BA;
  assign o_RAMReq        = (r_state == S_RAMRD) || (r_state == S_RAMWR);
  assign o_RAMWr         = (r_state == S_RAMWR);
  assign o_IncCA         = (r_state == S_ADV);
  assign o_IncREUA       = (r_state == S_ADV);
  assign o_DecLen        = (r_state == S_ADV);
  assign o_SetVerifyErr  = (r_state == S_ADV) && w_mismatch;
  // End of block is flagged on the last byte whether or not verify failed.
  assign o_SetEndOfBlock = (r_state == S_ADV) && i_Length1;
  assign o_XferEnd       = (r_state == S_DONE);
  assign o_Busy          = (r_state != S_IDLE);

endmodule

// File: doc/reu_dma_seq.md
Name: reu_dma_seq

Overview:
- DMA sequencer for the REU.
- Consumes Execute, transfer type and Length==1 from the REU register block. Drives C64-bus DMA cycles and the SDRAM controller request/acknowledge handshake.
- Returns per-byte strobes (IncCA, IncREUA, DecLen) and completion/status strobes (XferEnd, SetEndOfBlock, SetVerifyErr) to the register block.
- Byte data moves through an external datapath with two latches: C64Data, loaded on C64 reads, and RAMData, loaded on RAM reads. The sequencer supplies only control.

Parameters:
ARM_CYCLES, 1, number of PHI2 cycles DMA is held asserted before the first bus cycle (range 1..3).

Ports:
PHI2  input  1  C64 PHI2 clock; all state updates on falling edge.
Reset  input  1  synchronous active-high reset, sampled on falling edge of PHI2.
Execute  input  1  start request from register block.
XferType  input  2  00 stash, 01 fetch, 10 swap, 11 verify; already bypassed, valid during the Execute cycle.
Length1  input  1  remaining length == 1.
BA  input  1  C64 bus available; 0 = VIC owns the bus, stall C64 cycles.
RAMAck  input  1  one-cycle completion pulse from SDRAM controller.
DataEqual  input  1  C64Data == RAMData, from datapath.
DMA  output  1  request C64 bus (drives /DMA inverted externally).
C64Rd  output  1  C64 read strobe; datapath loads C64Data.
C64Wr  output  1  C64 write strobe; datapath drives RAMData onto bus.
RAMReq  output  1  SDRAM request, held until RAMAck.
RAMWr  output  1  SDRAM direction (1 write C64Data, 0 read into RAMData); valid while RAMReq.
IncCA, IncREUA, DecLen  output  1 each  per-byte advance strobes.
XferEnd  output  1  one-cycle end-of-transfer pulse.
SetEndOfBlock  output  1  one-cycle status pulse.
SetVerifyErr  output  1  one-cycle status pulse.
Busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, ARM, C64RD, C64WR, RAMRD, RAMWR, ADV, DONE. Encoding is free.
- Outputs are Moore-decoded from the state register, except where a qualifier is stated below. All outputs are 0 at reset and in IDLE.
- IDLE: on Execute, latch XferType into TypeQ, load the ARM counter with ARM_CYCLES, go to ARM.
- ARM: DMA=1. Count down, then go to the first step of TypeQ's sequence.
- Per-byte sequences, each ending in ADV:
  - stash: C64RD, RAMWR.
  - fetch: RAMRD, C64WR.
  - swap: RAMRD, C64RD, RAMWR, C64WR.
  - verify: RAMRD, C64RD.
- DMA=1 in every state from ARM through ADV. DMA=0 in DONE.
- C64RD / C64WR:
  - C64Rd (or C64Wr) = BA.
  - Advance only on a cycle with BA=1. With BA=0, hold state and emit no strobe. Stalls are unbounded.
- RAMRD / RAMWR:
  - RAMReq=1; RAMWr=1 in RAMWR only.
  - Advance on the cycle RAMAck=1. RAMReq drops in the next state.
  - RAMAck outside RAM states is ignored.
- ADV: exactly one cycle. IncCA=IncREUA=DecLen=1 (address-hold gating is done in the register block).
  - Verify mismatch (TypeQ=11 and DataEqual=0): SetVerifyErr=1, go to DONE. Also SetEndOfBlock=1 if Length1=1.
  - Otherwise, if Length1=1: SetEndOfBlock=1, go to DONE.
  - Otherwise, return to the first step of the sequence.
- Length1 is sampled in ADV, before the decrement takes effect. A programmed length of 0 therefore runs 65536 bytes.
- DONE: XferEnd=1 for one cycle, DMA=0, go to IDLE.
  - The register block's autoload and execute-clear use XferEnd.
  - Execute in the DONE cycle is ignored.
- Execute while Busy is ignored. TypeQ is not re-sampled mid-transfer.
- Reset in any state: next state IDLE, all outputs 0, no XferEnd or status pulse. An outstanding RAMReq is dropped; the SDRAM controller is reset by the same signal.
- At most one strobe of each kind per cycle. Never C64Rd and C64Wr together. Never RAMReq together with a C64 strobe.

Test Plan:
- Stash, ARM_CYCLES=1, BA=1, Length1=1, RAMAck one cycle after request → states IDLE,ARM,C64RD,RAMWR,RAMWR,ADV,DONE,IDLE. One each of C64Rd, RAMReq(RAMWr=1), Inc/Dec strobes, SetEndOfBlock, XferEnd. DMA high for 5 cycles.
- Fetch of 3 bytes (Length1 asserted only in the third ADV), BA toggled 0 for 4 cycles during the second C64WR → exactly 3 C64Wr and 3 DecLen pulses. No C64Wr while BA=0. XferEnd once, after the third ADV.
- Swap of 1 byte → strobe order RAMReq(RAMWr=0), C64Rd, RAMReq(RAMWr=1), C64Wr, then ADV, DONE.
- Verify of 4 bytes, DataEqual=0 on byte 2 → 2 DecLen pulses, SetVerifyErr once, no SetEndOfBlock, XferEnd once.
- Verify with mismatch on the last byte (Length1=1) → SetVerifyErr and SetEndOfBlock in the same cycle, then XferEnd.
- Reset asserted during RAMWR while waiting for RAMAck → next cycle IDLE, DMA=0, RAMReq=0, no XferEnd. A following Execute with type 01 starts a clean fetch; Execute pulses while Busy cause no restart.
